// File: rtl/lfsr_search_ctrl.sv
// -----------------------------------------------------------------------------
// lfsr_search_ctrl
//
// Shares one external LFSR between NUM_REQ photodiode bit decoders. Each
// request carries a captured 17-bit word and a polynomial select. The block
// runs the LFSR from START_DATA until its value equals that word, then reports
// the iteration count (the sweep offset). If no match is found by MAX_ITER
// steps, it reports a timeout instead. Requesters are served one at a time,
// in round-robin order.
//
// Ports
//   clk_72MHz        system clock, everything on the rising edge
//   rst_n            synchronous active-low reset
//   req_valid        per-requester request pending
//   req_target       per-requester captured word, requester i at [17*i +: 17]
//   req_poly_sel     per-requester polynomial select (0 = POLY_A, 1 = POLY_B)
//   req_ready        one-hot grant; a handshake is valid & ready
//   lfsr_polynomial  polynomial driven to the LFSR, latched at the handshake
//   lfsr_start_data  seed driven to the LFSR (constant START_DATA)
//   lfsr_enable      registered run enable for the LFSR
//   lfsr_value       current LFSR value
//   lfsr_iteration   current LFSR iteration number
//   resp_valid       one-cycle result pulse, no backpressure
//   resp_id          requester index of the result
//   resp_found       1 = match, 0 = timeout
//   resp_offset      iteration count at the match, or MAX_ITER on timeout
// -----------------------------------------------------------------------------
module lfsr_search_ctrl #(
    parameter int          NUM_REQ    = 4,
    parameter int          ID_W       = $clog2(NUM_REQ),
    parameter logic [16:0] POLY_A     = 17'h1D258,
    parameter logic [16:0] POLY_B     = 17'h17E04,
    parameter logic [16:0] START_DATA = 17'h00001,
    parameter logic [16:0] MAX_ITER   = 17'h1FFFF
) (
    input  logic                    clk_72MHz,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*17-1:0]   req_target,
    input  logic [NUM_REQ-1:0]      req_poly_sel,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [16:0]             lfsr_polynomial,
    output logic [16:0]             lfsr_start_data,
    output logic                    lfsr_enable,
    input  logic [16:0]             lfsr_value,
    input  logic [16:0]             lfsr_iteration,
    output logic                    resp_valid,
    output logic [ID_W-1:0]         resp_id,
    output logic                    resp_found,
    output logic [16:0]             resp_offset
);

    // COOL keeps the enable low long enough for the un-reset LFSR to return to
    // idle. WAIT1/WAIT2 cover the LFSR load latency before the first compare.
    typedef enum logic [2:0] {
        COOL,
        IDLE,
        WAIT1,
        WAIT2,
        SEARCH,
        RESP
    } state_t;

    state_t          state, state_next;
    logic            cool_cnt;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] win_idx;
    logic            grant_any;
    logic [16:0]     win_target;
    logic            win_poly;
    logic [16:0]     target_q;
    logic [ID_W-1:0] id_q;
    logic            hit;
    logic            at_max;
    logic            handshake;
    logic            search_done;

    assign lfsr_start_data = START_DATA;

    // Index arithmetic modulo NUM_REQ. This works for any count, not only
    // powers of two. Both arguments are below NUM_REQ.
    function automatic logic [ID_W-1:0] wrap_idx(input int base, input int offset);
        int sum;
        sum = base + offset;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        return ID_W'(sum);
    endfunction

    // Round-robin pick. The loop scans from farthest to nearest, so the valid
    // requester closest at or after rr_ptr is assigned last and wins.
    // NOTE: every signal driven in an always_comb gets a default before any
    // conditional assignment; otherwise synthesis infers a latch.
    always_comb begin
        grant_any = 1'b0;
        win_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[wrap_idx(int'(rr_ptr), i)]) begin
                grant_any = 1'b1;
                win_idx   = wrap_idx(int'(rr_ptr), i);
            end
        end
    end

    always_comb begin
        win_target = '0;
        win_poly   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ID_W'(i) == win_idx) begin
                win_target = req_target[17*i +: 17];
                win_poly   = req_poly_sel[i];
            end
        end
    end

    assign hit         = (lfsr_value == target_q);
    assign at_max      = (lfsr_iteration == MAX_ITER);
    assign handshake   = (state == IDLE) && grant_any;
    assign search_done = (state == SEARCH) && (hit || at_max);

    always_comb begin
        state_next = state;
        req_ready  = '0;
        case (state)
            COOL:    if (cool_cnt) state_next = IDLE;
            IDLE: begin
                if (grant_any) begin
                    req_ready[win_idx] = 1'b1;
                    state_next         = WAIT1;
                end
            end
            WAIT1:   state_next = WAIT2;
            WAIT2:   state_next = SEARCH;
            SEARCH:  if (hit || at_max) state_next = RESP;
            RESP:    state_next = COOL;
            default: state_next = COOL;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only. That way every
    // flop samples the values from before the edge, whatever the statement order.
    always_ff @(posedge clk_72MHz) begin
        if (!rst_n) begin
            state           <= COOL;
            cool_cnt        <= 1'b0;
            rr_ptr          <= '0;
            lfsr_enable     <= 1'b0;
            lfsr_polynomial <= '0;
            resp_valid      <= 1'b0;
            resp_id         <= '0;
            resp_found      <= 1'b0;
            resp_offset     <= '0;
        end else begin
            state      <= state_next;
            cool_cnt   <= (state == COOL) && !cool_cnt;
            resp_valid <= 1'b0;
            if (handshake) begin
                rr_ptr          <= wrap_idx(int'(win_idx), 1);
                lfsr_enable     <= 1'b1;
                lfsr_polynomial <= win_poly ? POLY_B : POLY_A;
            end
            // A match on the final iteration still counts as found.
            if (search_done) begin
                lfsr_enable <= 1'b0;
                resp_valid  <= 1'b1;
                resp_id     <= id_q;
                resp_found  <= hit;
                resp_offset <= hit ? lfsr_iteration : MAX_ITER;
            end
        end
    end

    // NOTE: the request payload registers have no reset. They are only read
    // after a handshake has loaded them, so a reset would add logic for nothing.
    always_ff @(posedge clk_72MHz) begin
        if (handshake) begin
            target_q <= win_target;
            id_q     <= win_idx;
        end
    end

endmodule
